// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
//
// Pipeline register between the execute (EX) and memory-access (MEM) stages
// of the 5-stage MIPS core.
//
// Every rising clk edge performs exactly one action. Higher entries win:
//   flush   : flush = 1
//             -> all MEM-side outputs and the multi-cycle temporary clear.
//   bubble  : stall[EX_IDX] = 1 and stall[MEM_IDX] = 0
//             -> a NOP goes to MEM. The temporary is loaded from EX, so a
//                two-cycle MADD/MSUB keeps its partial result.
//   hold    : stall[EX_IDX] = 1 and stall[MEM_IDX] = 1
//             -> every register keeps its value.
//   advance : stall[EX_IDX] = 0
//             -> the EX results move to MEM. The temporary has been
//                consumed, so it clears.
// The combination stall[EX_IDX] = 0 with stall[MEM_IDX] = 1 is never
// produced by stall control. It is treated as advance. All other stall bits
// are ignored.
//
// Optional feature, macro EX_MEM_BUBBLE_CNT_EN:
//   adds bubble_cnt_o, a 32-bit wrapping count of bubble edges. It is
//   cleared only by reset.
//
// Ports:
//   clk             pipeline clock, rising edge
//   rst             asynchronous reset, active low
//   stall           global stall vector; bit i holds stage i
//   flush           synchronous pipeline flush
//   ex_*            EX-stage results: wd, wreg, wdata, whilo, hi, lo, aluop,
//                   mem_addr, reg2
//   hilo_i, cnt_i   multi-cycle temporary and step count from EX
//   mem_*           registered copies of ex_* for MEM
//   hilo_o, cnt_o   registered temporary and step count fed back to EX
//   bubble_cnt_o    bubble edge count (only with EX_MEM_BUBBLE_CNT_EN)
// ---------------------------------------------------------------------------
module ex_mem_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 8,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    ex_wd,
  input  logic                 ex_wreg,
  input  logic [DATA_W-1:0]    ex_wdata,
  input  logic                 ex_whilo,
  input  logic [DATA_W-1:0]    ex_hi,
  input  logic [DATA_W-1:0]    ex_lo,
  input  logic [ALUOP_W-1:0]   ex_aluop,
  input  logic [DATA_W-1:0]    ex_mem_addr,
  input  logic [DATA_W-1:0]    ex_reg2,
  input  logic [2*DATA_W-1:0]  hilo_i,
  input  logic [1:0]           cnt_i,
  output logic [ADDR_W-1:0]    mem_wd,
  output logic                 mem_wreg,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_whilo,
  output logic [DATA_W-1:0]    mem_hi,
  output logic [DATA_W-1:0]    mem_lo,
  output logic [ALUOP_W-1:0]   mem_aluop,
  output logic [DATA_W-1:0]    mem_mem_addr,
  output logic [DATA_W-1:0]    mem_reg2,
  output logic [2*DATA_W-1:0]  hilo_o,
  output logic [1:0]           cnt_o
`ifdef EX_MEM_BUBBLE_CNT_EN
  ,
  output logic [31:0]          bubble_cnt_o
`endif
);

  // -------------------------------------------------------------------------
  // Payload carried from EX to MEM. It is bundled so that clear, hold and
  // load are each a single assignment.
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [ADDR_W-1:0]  wd;
    logic               wreg;
    logic [DATA_W-1:0]  wdata;
    logic               whilo;
    logic [DATA_W-1:0]  hi;
    logic [DATA_W-1:0]  lo;
    logic [ALUOP_W-1:0] aluop;
    logic [DATA_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  reg2;
  } stage_t;

  // Action taken on the coming edge, decoded once from flush and stall.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } action_e;

  action_e             action;
  stage_t              ex_bus;
  stage_t              stage_d, stage_q;
  logic [2*DATA_W-1:0] hilo_d,  hilo_q;
  logic [1:0]          cnt_d,   cnt_q;

  // Only stall[EX_IDX] and stall[MEM_IDX] matter; the other bits are
  // folded in here so that they are visibly consumed.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall;

  assign ex_bus = '{
    wd:       ex_wd,
    wreg:     ex_wreg,
    wdata:    ex_wdata,
    whilo:    ex_whilo,
    hi:       ex_hi,
    lo:       ex_lo,
    aluop:    ex_aluop,
    mem_addr: ex_mem_addr,
    reg2:     ex_reg2
  };

  // -------------------------------------------------------------------------
  // Action decode. The if/else chain sets the priority:
  // flush > bubble > hold > advance.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in always_comb receives a default on
    // entry. Without it, a path that skips an assignment infers a latch.
    action = ACT_ADVANCE;
    if (flush) begin
      action = ACT_FLUSH;
    end else if (stall[EX_IDX] && !stall[MEM_IDX]) begin
      action = ACT_BUBBLE;
    end else if (stall[EX_IDX]) begin
      action = ACT_HOLD;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. The defaults keep every register at its current value,
  // which already covers the hold action.
  // -------------------------------------------------------------------------
  always_comb begin
    stage_d = stage_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
    unique case (action)
      ACT_FLUSH: begin
        stage_d = '0;
        hilo_d  = '0;
        cnt_d   = '0;
      end
      ACT_BUBBLE: begin
        // A NOP goes to MEM. The partial MADD/MSUB result still has to come
        // back to EX on the next cycle, so the temporary is loaded.
        stage_d = '0;
        hilo_d  = hilo_i;
        cnt_d   = cnt_i;
      end
      ACT_HOLD: begin
        stage_d = stage_q;
      end
      ACT_ADVANCE: begin
        // EX has consumed the temporary, so it clears.
        stage_d = ex_bus;
        hilo_d  = '0;
        cnt_d   = '0;
      end
      default: begin
        stage_d = '0;
        hilo_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. The reset clears the temporary together with the
  // payload, so a step count held during a stall does not survive a reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample the pre-edge values, independent of statement order.
    if (!rst) begin
      stage_q <= '0;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd       = stage_q.wd;
  assign mem_wreg     = stage_q.wreg;
  assign mem_wdata    = stage_q.wdata;
  assign mem_whilo    = stage_q.whilo;
  assign mem_hi       = stage_q.hi;
  assign mem_lo       = stage_q.lo;
  assign mem_aluop    = stage_q.aluop;
  assign mem_mem_addr = stage_q.mem_addr;
  assign mem_reg2     = stage_q.reg2;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;

`ifdef EX_MEM_BUBBLE_CNT_EN
  // -------------------------------------------------------------------------
  // Bubble counter. It counts only on the bubble action. A flush edge has
  // already been decoded as ACT_FLUSH, so it never counts. The 32-bit add
  // wraps 0xFFFFFFFF back to 0 on its own.
  // -------------------------------------------------------------------------
  logic [31:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (action == ACT_BUBBLE) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg
//
// Self-checking bench for ex_mem_reg.
//
// A reference model predicts the registered outputs for each edge from the
// inputs driven before that edge. The prediction is pushed to a scoreboard
// queue. It is popped and compared against the DUT one time unit after the
// edge. Asynchronous reset is checked directly, with no clock edge involved.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int ALUOP_W = 8;
  localparam int STALL_W = 6;
  localparam int EX_IDX  = 3;
  localparam int MEM_IDX = 4;

  localparam logic [STALL_W-1:0] ST_ADV    = 6'b000000;
  localparam logic [STALL_W-1:0] ST_BUBBLE = 6'b001111;
  localparam logic [STALL_W-1:0] ST_HOLD   = 6'b011111;

  // Predicted register contents after one edge.
  typedef struct {
    logic [ADDR_W-1:0]   wd;
    logic                wreg;
    logic [DATA_W-1:0]   wdata;
    logic                whilo;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic [ALUOP_W-1:0]  aluop;
    logic [DATA_W-1:0]   addr;
    logic [DATA_W-1:0]   reg2;
    logic [2*DATA_W-1:0] hilo;
    logic [1:0]          cnt;
    logic [31:0]         bcnt;
  } exp_t;

  logic                clk;
  logic                rst;
  logic [STALL_W-1:0]  stall;
  logic                flush;
  logic [ADDR_W-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_whilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [DATA_W-1:0]   ex_mem_addr;
  logic [DATA_W-1:0]   ex_reg2;
  logic [2*DATA_W-1:0] hilo_i;
  logic [1:0]          cnt_i;
  logic [ADDR_W-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_whilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic [ALUOP_W-1:0]  mem_aluop;
  logic [DATA_W-1:0]   mem_mem_addr;
  logic [DATA_W-1:0]   mem_reg2;
  logic [2*DATA_W-1:0] hilo_o;
  logic [1:0]          cnt_o;
`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [31:0]         bubble_cnt_o;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t model;
  exp_t sb[$];

  ex_mem_reg #(
    .DATA_W (DATA_W),  .ADDR_W (ADDR_W),   .ALUOP_W(ALUOP_W),
    .STALL_W(STALL_W), .EX_IDX (EX_IDX),   .MEM_IDX(MEM_IDX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .ex_wd       (ex_wd),
    .ex_wreg     (ex_wreg),
    .ex_wdata    (ex_wdata),
    .ex_whilo    (ex_whilo),
    .ex_hi       (ex_hi),
    .ex_lo       (ex_lo),
    .ex_aluop    (ex_aluop),
    .ex_mem_addr (ex_mem_addr),
    .ex_reg2     (ex_reg2),
    .hilo_i      (hilo_i),
    .cnt_i       (cnt_i),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .mem_whilo   (mem_whilo),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
    .mem_aluop   (mem_aluop),
    .mem_mem_addr(mem_mem_addr),
    .mem_reg2    (mem_reg2),
    .hilo_o      (hilo_o),
    .cnt_o       (cnt_o)
`ifdef EX_MEM_BUBBLE_CNT_EN
    ,
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stall control must never hold MEM while EX advances.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(!stall[EX_IDX] && stall[MEM_IDX]))
        else $error("illegal stall vector %b", stall);
    end
  end

  // Guard against a hung run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".mem_wd"},       64'(mem_wd),       64'(e.wd));
    check({tag, ".mem_wreg"},     64'(mem_wreg),     64'(e.wreg));
    check({tag, ".mem_wdata"},    64'(mem_wdata),    64'(e.wdata));
    check({tag, ".mem_whilo"},    64'(mem_whilo),    64'(e.whilo));
    check({tag, ".mem_hi"},       64'(mem_hi),       64'(e.hi));
    check({tag, ".mem_lo"},       64'(mem_lo),       64'(e.lo));
    check({tag, ".mem_aluop"},    64'(mem_aluop),    64'(e.aluop));
    check({tag, ".mem_mem_addr"}, 64'(mem_mem_addr), 64'(e.addr));
    check({tag, ".mem_reg2"},     64'(mem_reg2),     64'(e.reg2));
    check({tag, ".hilo_o"},       hilo_o,            e.hilo);
    check({tag, ".cnt_o"},        64'(cnt_o),        64'(e.cnt));
`ifdef EX_MEM_BUBBLE_CNT_EN
    check({tag, ".bubble_cnt_o"}, 64'(bubble_cnt_o), 64'(e.bcnt));
`endif
  endtask

  // Predict the next edge from the current inputs.
  function automatic exp_t predict(input exp_t cur);
    exp_t n;
    n = cur;
    if (flush) begin
      n = '{default: '0};
      n.bcnt = cur.bcnt;
    end else if (stall[EX_IDX] && !stall[MEM_IDX]) begin
      n = '{default: '0};
      n.hilo = hilo_i;
      n.cnt  = cnt_i;
      n.bcnt = cur.bcnt + 32'd1;
    end else if (stall[EX_IDX]) begin
      n = cur;
    end else begin
      n.wd = ex_wd;       n.wreg = ex_wreg;   n.wdata = ex_wdata;
      n.whilo = ex_whilo; n.hi = ex_hi;       n.lo = ex_lo;
      n.aluop = ex_aluop; n.addr = ex_mem_addr; n.reg2 = ex_reg2;
      n.hilo = '0;        n.cnt = '0;
    end
    return n;
  endfunction

  // Inputs are already set; called with clk low. Returns with clk low.
  task automatic step(input string tag);
    exp_t e;
    model = predict(model);
    sb.push_back(model);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      compare(tag, e);
    end
    @(negedge clk);
  endtask

  task automatic set_ex(input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
  endtask

  task automatic randomize_ex();
    ex_wd       = 5'($urandom);
    ex_wreg     = 1'($urandom);
    ex_wdata    = $urandom;
    ex_whilo    = 1'($urandom);
    ex_hi       = $urandom;
    ex_lo       = $urandom;
    ex_aluop    = 8'($urandom);
    ex_mem_addr = $urandom;
    ex_reg2     = $urandom;
    hilo_i      = {$urandom, $urandom};
    cnt_i       = 2'($urandom);
  endtask

  // Asynchronous reset pulse taken while clk is low. The outputs are checked
  // with no edge in between.
  task automatic async_reset(input string tag);
    exp_t z;
    z = '{default: '0};
    #2;
    rst = 1'b0;
    #1;
    compare(tag, z);
    model = z;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model = '{default: '0};
    rst   = 1'b0;
    flush = 1'b0;
    stall = ST_ADV;
    randomize_ex();
    ex_wreg = 1'b1; ex_whilo = 1'b1; ex_wd = 5'd7; cnt_i = 2'd2;

    // Reset with nonzero inputs: outputs are zero before any clock edge.
    #3;
    compare("reset_no_clk", model);
    @(negedge clk);
    @(negedge clk);
    compare("reset_held", model);
    rst = 1'b1;

    // First transfer after reset.
    set_ex(5'd3, 1'b1, 32'h1234_5678);
    step("first_adv");

    // Bubble keeps the partial temporary; the next advance clears it.
    randomize_ex();
    hilo_i = 64'hDEAD_BEEF_0000_0001; cnt_i = 2'd1;
    stall  = ST_BUBBLE;
    step("bubble");
    randomize_ex();
    stall = ST_ADV;
    step("after_bubble_adv");

    // Hold for three cycles while EX keeps changing.
    set_ex(5'd9, 1'b1, 32'hA5A5_A5A5);
    step("load_a5");
    stall = ST_HOLD;
    for (int i = 0; i < 3; i++) begin
      randomize_ex();
      step($sformatf("hold%0d", i));
    end

    // Flush wins over hold.
    flush = 1'b1;
    step("flush_over_hold");
    flush = 1'b0;

    // HI/LO path, then flush.
    stall = ST_ADV;
    randomize_ex();
    ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2;
    step("hilo_adv");
    flush = 1'b1;
    step("hilo_flush");
    flush = 1'b0;

    // Flush wins over bubble.
    stall = ST_BUBBLE;
    flush = 1'b1;
    randomize_ex();
    step("flush_over_bubble");
    flush = 1'b0;

    // Ignored stall bits with the other bits set to advance and to bubble.
    stall = 6'b100111;
    randomize_ex();
    step("ignored_bits_adv");
    stall = 6'b101000;
    randomize_ex();
    step("ignored_bits_bubble");

    // Reset during a hold drops the held temporary.
    stall = ST_HOLD;
    randomize_ex();
    step("hold_with_temp");
    async_reset("reset_mid_stall");
    stall = ST_ADV;
    randomize_ex();
    step("post_reset_adv");

`ifdef EX_MEM_BUBBLE_CNT_EN
    // 5 bubbles, 1 flush, 2 advances -> a count of 5 above the reset value.
    async_reset("bcnt_reset");
    for (int i = 0; i < 5; i++) begin
      stall = ST_BUBBLE; randomize_ex(); step("bcnt_bubble");
    end
    flush = 1'b1; step("bcnt_flush"); flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stall = ST_ADV; randomize_ex(); step("bcnt_adv");
    end
    check("bcnt_total", 64'(bubble_cnt_o), 64'd5);

    // Wrap from all ones to zero.
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    model.bcnt = 32'hFFFF_FFFF;
    stall = ST_BUBBLE; randomize_ex(); step("bcnt_wrap");
    stall = ST_ADV;
`endif

    // Random mix of all legal actions.
    for (int i = 0; i < 300; i++) begin
      int r;
      randomize_ex();
      r = $urandom_range(0, 9);
      if (r < 5)      stall = STALL_W'($urandom) & 6'b100111;
      else if (r < 7) stall = (STALL_W'($urandom) & 6'b100111) | 6'b001000;
      else            stall = (STALL_W'($urandom) & 6'b100111) | 6'b011000;
      flush = ($urandom_range(0, 9) == 0);
      step("random");
    end
    flush = 1'b0;
    stall = ST_ADV;

    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
